// File: rtl/mem_responder.sv
// Shared-memory responder: one request at a time, WAIT_CYCLES wait states, one-cycle pronto.
// Define MEM_ALIGN_CHK_EN to flag misaligned or out-of-range addresses instead of wrapping them.
module mem_responder #(
  parameter int DEPTH       = 1024,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] address,
  input  logic [31:0] dadoW,
  input  logic        lerMem,
  input  logic        escMem,
  output logic [31:0] out,
  output logic        pronto,
  output logic        erro,
  output logic        ocupado
);

  localparam int AW = $clog2(DEPTH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_e;

  state_e          state_q, state_d;
  logic [3:0]      cnt_q, cnt_d;
  logic [AW-1:0]   addr_q, addr_d;
  logic [31:0]     data_q, data_d;
  logic            wr_q, wr_d;
  logic            err_q, err_d;
  logic [31:0]     out_q, out_d;
  logic            pronto_q, pronto_d;
  logic            erro_q, erro_d;
  logic            ocupado_q, ocupado_d;
  logic            mem_we_s;
  logic            bad_addr_s;
  logic [31:0]     mem_q [DEPTH];

`ifdef MEM_ALIGN_CHK_EN
  assign bad_addr_s = (address[1:0] != 2'b00) || (|address[31:AW+2]);
`else
  // Low byte-offset bits and bits above the word index are don't-care when wrapping.
  logic unused_addr_s;
  assign unused_addr_s = ^{address[1:0], address[31:AW+2]};
  assign bad_addr_s    = 1'b0;
`endif

  // Next-state, transaction capture and output computation.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    addr_d    = addr_q;
    data_d    = data_q;
    wr_d      = wr_q;
    err_d     = err_q;
    out_d     = out_q;
    mem_we_s  = 1'b0;
    case (state_q)
      IDLE: begin
        if (lerMem || escMem) begin
          addr_d  = address[2 +: AW];
          data_d  = dadoW;
          wr_d    = escMem;
          err_d   = (lerMem && escMem) || bad_addr_s;
          cnt_d   = 4'(WAIT_CYCLES);
          state_d = BUSY;
        end else begin
          state_d = IDLE;
        end
      end
      BUSY: begin
        if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          state_d = RESP;
          // Flagged transactions touch neither the array nor out.
          if (err_q) begin
            mem_we_s = 1'b0;
          end else if (wr_q) begin
            mem_we_s = 1'b1;
          end else begin
            out_d = mem_q[addr_q];
          end
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    pronto_d  = (state_d == RESP);
    erro_d    = (state_d == RESP) && err_d;
    ocupado_d = (state_d != IDLE);
  end

  // Control and output registers; reset aborts any in-flight transaction.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      cnt_q     <= 4'd0;
      addr_q    <= '0;
      data_q    <= 32'd0;
      wr_q      <= 1'b0;
      err_q     <= 1'b0;
      out_q     <= 32'd0;
      pronto_q  <= 1'b0;
      erro_q    <= 1'b0;
      ocupado_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      addr_q    <= addr_d;
      data_q    <= data_d;
      wr_q      <= wr_d;
      err_q     <= err_d;
      out_q     <= out_d;
      pronto_q  <= pronto_d;
      erro_q    <= erro_d;
      ocupado_q <= ocupado_d;
    end
  end

  // Word array; contents survive reset.
  always_ff @(posedge clock) begin
    if (mem_we_s) begin
      mem_q[addr_q] <= data_q;
    end
  end

  assign out     = out_q;
  assign pronto  = pronto_q;
  assign erro    = erro_q;
  assign ocupado = ocupado_q;

endmodule

// File: tb/tb_mem_responder.sv
// Scoreboard bench for mem_responder (DEPTH=1024, WAIT_CYCLES=2); honours MEM_ALIGN_CHK_EN.
module tb_mem_responder;

  localparam int DEPTH = 1024;
  localparam int WAITC = 2;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] address = 32'd0;
  logic [31:0] dadoW = 32'd0;
  logic        lerMem = 1'b0;
  logic        escMem = 1'b0;
  logic [31:0] out;
  logic        pronto;
  logic        erro;
  logic        ocupado;

  mem_responder #(.DEPTH(DEPTH), .WAIT_CYCLES(WAITC)) dut (
    .clock(clock), .reset(reset), .address(address), .dadoW(dadoW),
    .lerMem(lerMem), .escMem(escMem), .out(out), .pronto(pronto),
    .erro(erro), .ocupado(ocupado)
  );

  always #5 clock = ~clock;

  int total = 0;
  int bad = 0;
  logic [31:0] mdl_mem [int];
  logic [31:0] last_out = 32'd0;
  logic [32:0] exp_q [$];
  logic        prev_pronto = 1'b0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] expv);
    total++;
    if (got !== expv) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, expv);
    end
  endtask

  // Reference model: returns {erro, out} expected with the pronto of this request.
  task automatic predict(input logic [31:0] a, input logic [31:0] d, input logic rd,
                         input logic wr, output logic [32:0] e);
    int  word;
    logic err;
    word = int'((a >> 2) % DEPTH);
    err  = rd && wr;
`ifdef MEM_ALIGN_CHK_EN
    if (a[1:0] != 2'b00 || a >= 32'(DEPTH * 4)) err = 1'b1;
`endif
    if (err) begin
      e = {1'b1, last_out};
    end else if (wr) begin
      mdl_mem[word] = d;
      e = {1'b0, last_out};
    end else begin
      last_out = mdl_mem[word];
      e = {1'b0, last_out};
    end
  endtask

  always @(negedge clock) begin
    logic [32:0] e;
    if (!reset && pronto) begin
      chk("pronto_single_cycle", {63'd0, prev_pronto}, 64'd0);
      if (exp_q.size() == 0) begin
        chk("unexpected_pronto", 64'd1, 64'd0);
      end else begin
        e = exp_q.pop_front();
        chk("out", {32'd0, out}, {32'd0, e[31:0]});
        chk("erro", {63'd0, erro}, {63'd0, e[32]});
      end
    end
    prev_pronto <= pronto;
  end

  task automatic do_req(input logic [31:0] a, input logic [31:0] d, input logic rd,
                        input logic wr, input bit corrupt, input bit keep,
                        input logic [31:0] next_a);
    logic [32:0] e;
    int k;
    bit seen;
    @(negedge clock);
    address = a; dadoW = d; lerMem = rd; escMem = wr;
    predict(a, d, rd, wr, e);
    exp_q.push_back(e);
    seen = 0;
    k = 0;
    while (!seen && k < 20) begin
      @(negedge clock);
      k++;
      if (k == 1) begin
        chk("ocupado_busy", {63'd0, ocupado}, 64'd1);
        if (corrupt) begin
          address = 32'h80; escMem = 1'b1; dadoW = 32'h12345678;
        end
      end
      if (pronto) seen = 1;
    end
    chk("latency", 64'(k), 64'(WAITC + 2));
    if (keep) begin
      address = next_a;
      predict(next_a, 32'd0, 1'b1, 1'b0, e);
      exp_q.push_back(e);
    end else begin
      lerMem = 1'b0; escMem = 1'b0;
    end
  endtask

  initial begin
    int g;
    logic [31:0] a;
    logic [31:0] d;
    repeat (2) @(negedge clock);
    chk("rst_out", {32'd0, out}, 64'd0);
    chk("rst_pronto", {63'd0, pronto}, 64'd0);
    chk("rst_erro", {63'd0, erro}, 64'd0);
    chk("rst_ocupado", {63'd0, ocupado}, 64'd0);
    reset = 1'b0;

    // Basic write then read back
    do_req(32'h40, 32'hCAFEF00D, 1'b0, 1'b1, 0, 0, 32'd0);
    do_req(32'h40, 32'd0, 1'b1, 1'b0, 0, 0, 32'd0);
    do_req(32'h44, 32'h01234567, 1'b0, 1'b1, 0, 0, 32'd0);
    do_req(32'h80, 32'h0BADF00D, 1'b0, 1'b1, 0, 0, 32'd0);
    do_req(32'h10, 32'h00000000, 1'b0, 1'b1, 0, 0, 32'd0);

    // Reset pulsed mid-BUSY aborts the write
    @(negedge clock);
    address = 32'h10; dadoW = 32'hDEADBEEF; escMem = 1'b1;
    repeat (2) @(negedge clock);
    reset = 1'b1; escMem = 1'b0;
    #1;
    chk("abort_out", {32'd0, out}, 64'd0);
    chk("abort_pronto", {63'd0, pronto}, 64'd0);
    chk("abort_erro", {63'd0, erro}, 64'd0);
    chk("abort_ocupado", {63'd0, ocupado}, 64'd0);
    last_out = 32'd0;
    @(negedge clock);
    reset = 1'b0;
    do_req(32'h10, 32'd0, 1'b1, 1'b0, 0, 0, 32'd0);

    // Held read strobe: two back-to-back transactions
    do_req(32'h40, 32'd0, 1'b1, 1'b0, 0, 1, 32'h44);
    g = 0;
    do begin
      @(negedge clock);
      if (!pronto) g++;
    end while (!pronto && g < 20);
    chk("b2b_gap", 64'(g), 64'd4);
    lerMem = 1'b0;

    // Dual strobe is illegal
    do_req(32'h40, 32'h11111111, 1'b1, 1'b1, 0, 0, 32'd0);
    do_req(32'h40, 32'd0, 1'b1, 1'b0, 0, 0, 32'd0);

    // Inputs changed during BUSY must be ignored
    do_req(32'h40, 32'd0, 1'b1, 1'b0, 1, 0, 32'd0);
    do_req(32'h80, 32'd0, 1'b1, 1'b0, 0, 0, 32'd0);

`ifdef MEM_ALIGN_CHK_EN
    do_req(32'h42, 32'h55555555, 1'b0, 1'b1, 0, 0, 32'd0);
    do_req(32'h1000, 32'h66666666, 1'b0, 1'b1, 0, 0, 32'd0);
    do_req(32'h40, 32'd0, 1'b1, 1'b0, 0, 0, 32'd0);
`else
    do_req(32'h1002, 32'hA5A5A5A5, 1'b0, 1'b1, 0, 0, 32'd0);
    do_req(32'h0, 32'd0, 1'b1, 1'b0, 0, 0, 32'd0);
`endif

    // A few random-data word round trips
    for (int i = 0; i < 4; i++) begin
      a = 32'h100 + 32'(i * 4);
      d = $urandom;
      do_req(a, d, 1'b0, 1'b1, 0, 0, 32'd0);
      do_req(a, 32'd0, 1'b1, 1'b0, 0, 0, 32'd0);
    end

    repeat (3) @(negedge clock);
    chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
